// File: rtl/cache_arbiter_pkg.sv
// Shared LC-3b types for the cache/memory arbiter: line type, arbiter states
// and operation encoding, plus default widths.
package cache_arbiter_pkg;

   localparam int ADDR_WIDTH_DEF = 16;
   localparam int LINE_WIDTH_DEF = 128;

   typedef logic [15:0]  lc3b_word;
   typedef logic [127:0] lc3b_line;

   typedef enum logic [1:0] {
      arb_idle,
      arb_serve_i,
      arb_serve_d
   } lc3b_arb_state;

   typedef enum logic {
      arb_op_read,
      arb_op_write
   } lc3b_arb_op;

endpackage

// File: rtl/cache_arbiter_if.sv
// Bundle of icache, dcache and physical-memory signals around the arbiter.
// The slave modport is the arbiter's view; master is the caches/memory side.
interface cache_arbiter_if
   import cache_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int LINE_WIDTH = LINE_WIDTH_DEF
);

   logic                  i_read;
   logic [ADDR_WIDTH-1:0] i_address;
   logic [LINE_WIDTH-1:0] i_rdata;
   logic                  i_resp;

   logic                  d_read;
   logic                  d_write;
   logic [ADDR_WIDTH-1:0] d_address;
   logic [LINE_WIDTH-1:0] d_wdata;
   logic [LINE_WIDTH-1:0] d_rdata;
   logic                  d_resp;

   logic                  pmem_read;
   logic                  pmem_write;
   logic [ADDR_WIDTH-1:0] pmem_address;
   logic [LINE_WIDTH-1:0] pmem_wdata;
   logic [LINE_WIDTH-1:0] pmem_rdata;
   logic                  pmem_resp;

   logic                  busy;

   modport slave (
      input  i_read, i_address, d_read, d_write, d_address, d_wdata,
             pmem_rdata, pmem_resp,
      output i_rdata, i_resp, d_rdata, d_resp,
             pmem_read, pmem_write, pmem_address, pmem_wdata, busy
   );

   modport master (
      output i_read, i_address, d_read, d_write, d_address, d_wdata,
             pmem_rdata, pmem_resp,
      input  i_rdata, i_resp, d_rdata, d_resp,
             pmem_read, pmem_write, pmem_address, pmem_wdata, busy
   );

endinterface

// File: rtl/cache_arb_pick.sv
// Combinational grant selection between icache and dcache requests.
// CACHE_ARB_RR_EN selects round-robin on ties; otherwise dcache always wins.
module cache_arb_pick
   import cache_arbiter_pkg::*;
(
   input  logic iReq_i,
   input  logic dReq_i,
`ifdef CACHE_ARB_RR_EN
   input  logic lastGrantD_i,
`endif
   output logic grantI_o,
   output logic grantD_o
);

`ifdef CACHE_ARB_RR_EN
   // On a tie the requester that was not granted last takes the port.
   assign grantD_o = dReq_i && (!iReq_i || !lastGrantD_i);
`else
   assign grantD_o = dReq_i;
`endif
   assign grantI_o = iReq_i && !grantD_o;

endmodule

// File: rtl/cache_arbiter.sv
// Shares the physical-memory port between the LC-3b icache and dcache.
// Optional round-robin tie-breaking is enabled with CACHE_ARB_RR_EN.
module cache_arbiter
   import cache_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int LINE_WIDTH = LINE_WIDTH_DEF
)(
   input  logic            clk,
   input  logic            rst_n,
   cache_arbiter_if.slave  bus
);

   lc3b_arb_state         state_q, state_d;
   lc3b_arb_op            op_q, op_d;
   logic [ADDR_WIDTH-1:0] holdAddr_q, holdAddr_d;
   logic [LINE_WIDTH-1:0] holdWdata_q, holdWdata_d;
   logic [LINE_WIDTH-1:0] iRdata_q, iRdata_d;
   logic [LINE_WIDTH-1:0] dRdata_q, dRdata_d;
   logic                  grantI, grantD;

`ifdef CACHE_ARB_RR_EN
   logic                  lastGrantD_q, lastGrantD_d;
`endif

   cache_arb_pick u_pick (
      .iReq_i       (bus.i_read),
      .dReq_i       (bus.d_read | bus.d_write),
`ifdef CACHE_ARB_RR_EN
      .lastGrantD_i (lastGrantD_q),
`endif
      .grantI_o     (grantI),
      .grantD_o     (grantD)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= arb_idle;
         op_q        <= arb_op_read;
         holdAddr_q  <= '0;
         holdWdata_q <= '0;
         iRdata_q    <= '0;
         dRdata_q    <= '0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         holdAddr_q  <= holdAddr_d;
         holdWdata_q <= holdWdata_d;
         iRdata_q    <= iRdata_d;
         dRdata_q    <= dRdata_d;
      end
   end

`ifdef CACHE_ARB_RR_EN
   always_comb begin
      lastGrantD_d = lastGrantD_q;
      if (state_q == arb_idle && grantD)
         lastGrantD_d = 1'b1;
      else if (state_q == arb_idle && grantI)
         lastGrantD_d = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         lastGrantD_q <= 1'b0;
      else
         lastGrantD_q <= lastGrantD_d;
   end
`endif

   // Memory is driven only from the holding registers so a requester that
   // drops or changes its inputs mid-serve cannot disturb the transaction.
   always_comb begin
      state_d      = state_q;
      op_d         = op_q;
      holdAddr_d   = holdAddr_q;
      holdWdata_d  = holdWdata_q;
      iRdata_d     = iRdata_q;
      dRdata_d     = dRdata_q;
      bus.i_resp     = 1'b0;
      bus.d_resp     = 1'b0;
      bus.i_rdata    = iRdata_q;
      bus.d_rdata    = dRdata_q;
      bus.pmem_read  = 1'b0;
      bus.pmem_write = 1'b0;

      case (state_q)
         arb_idle: begin
            if (grantD) begin
               op_d        = bus.d_write ? arb_op_write : arb_op_read;
               holdAddr_d  = bus.d_address;
               holdWdata_d = bus.d_wdata;
               state_d     = arb_serve_d;
            end else if (grantI) begin
               op_d        = arb_op_read;
               holdAddr_d  = bus.i_address;
               state_d     = arb_serve_i;
            end
         end
         arb_serve_i, arb_serve_d: begin
            bus.pmem_read  = (op_q == arb_op_read);
            bus.pmem_write = (op_q == arb_op_write);
            if (bus.pmem_resp) begin
               state_d = arb_idle;
               if (state_q == arb_serve_i) begin
                  bus.i_resp  = 1'b1;
                  bus.i_rdata = bus.pmem_rdata;
                  iRdata_d    = bus.pmem_rdata;
               end else begin
                  bus.d_resp  = 1'b1;
                  bus.d_rdata = bus.pmem_rdata;
                  dRdata_d    = bus.pmem_rdata;
               end
            end
         end
         default: state_d = arb_idle;
      endcase
   end

   assign bus.pmem_address = holdAddr_q;
   assign bus.pmem_wdata   = holdWdata_q;
   assign bus.busy         = (state_q != arb_idle);

endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench for cache_arbiter: directed sequences drive the caches
// and a memory model; a scoreboard queue matches every resp pulse.
module tb_cache_arbiter;
   import cache_arbiter_pkg::*;

   localparam int AW = 16;
   localparam int LW = 128;

   logic clk = 1'b0;
   logic rst_n;
   int   checkCount = 0;
   int   errorCount = 0;

   typedef struct {
      bit            isD;
      logic [LW-1:0] rdata;
   } expT;

   expT expQ[$];
   expT monE;

   cache_arbiter_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) bus();

   cache_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Counts one comparison and reports it when the values differ.
   task automatic checkOutput(input string tag, input logic [LW-1:0] actual,
                              input logic [LW-1:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic iRead, input logic [AW-1:0] iAddr,
                                input logic dRead, input logic dWrite,
                                input logic [AW-1:0] dAddr, input logic [LW-1:0] dWdata);
      bus.i_read    = iRead;
      bus.i_address = iAddr;
      bus.d_read    = dRead;
      bus.d_write   = dWrite;
      bus.d_address = dAddr;
      bus.d_wdata   = dWdata;
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic checkIdle(input string tag);
      @(negedge clk);
      checkOutput({tag, " pmem_read"}, bus.pmem_read, 1'b0);
      checkOutput({tag, " pmem_write"}, bus.pmem_write, 1'b0);
      checkOutput({tag, " busy"}, bus.busy, 1'b0);
   endtask

   // Called just after the edge that enters a serve state; models memory
   // that answers after waitCycles and queues the resp the cache should see.
   task automatic serveMem(input string tag, input bit isD, input bit isWrite,
                           input logic [AW-1:0] addr, input logic [LW-1:0] wdata,
                           input int waitCycles, input logic [LW-1:0] rdata);
      expT e;
      for (int k = 0; k < waitCycles; k++) begin
         @(negedge clk);
         checkOutput({tag, " pmem_read"}, bus.pmem_read, !isWrite);
         checkOutput({tag, " pmem_write"}, bus.pmem_write, isWrite);
         checkOutput({tag, " pmem_address"}, bus.pmem_address, addr);
         checkOutput({tag, " busy"}, bus.busy, 1'b1);
         if (isWrite)
            checkOutput({tag, " pmem_wdata"}, bus.pmem_wdata, wdata);
         nextCycle();
      end
      e.isD   = isD;
      e.rdata = rdata;
      expQ.push_back(e);
      bus.pmem_rdata = rdata;
      bus.pmem_resp  = 1'b1;
      @(negedge clk);
      checkOutput({tag, " strobe at resp"}, isWrite ? bus.pmem_write : bus.pmem_read, 1'b1);
      nextCycle();
      bus.pmem_resp  = 1'b0;
      bus.pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
   endtask

   // Scoreboard: every resp pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (bus.i_resp || bus.d_resp) begin
         if (expQ.size() == 0) begin
            checkOutput("unexpected resp", {bus.i_resp, bus.d_resp}, '0);
         end else begin
            monE = expQ.pop_front();
            checkOutput("resp i_resp", bus.i_resp, !monE.isD);
            checkOutput("resp d_resp", bus.d_resp, monE.isD);
            checkOutput("resp rdata", monE.isD ? bus.d_rdata : bus.i_rdata, monE.rdata);
         end
      end
   end

   initial begin
      logic [LW-1:0] lineA;
      logic [LW-1:0] lineB;

      rst_n          = 1'b0;
      bus.pmem_resp  = 1'b0;
      bus.pmem_rdata = '0;
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
      #12;
      checkOutput("reset pmem_read", bus.pmem_read, 1'b0);
      checkOutput("reset pmem_write", bus.pmem_write, 1'b0);
      checkOutput("reset busy", bus.busy, 1'b0);
      checkOutput("reset pmem_address", bus.pmem_address, '0);
      checkOutput("reset i_rdata", bus.i_rdata, '0);
      checkOutput("reset d_rdata", bus.d_rdata, '0);
      nextCycle();
      rst_n = 1'b1;

      $display("[TB] icache read alone");
      nextCycle();
      applyStimulus(1'b1, 16'h0040, 1'b0, 1'b0, '0, '0);
      checkIdle("t1 request cycle");
      nextCycle();
      serveMem("t1", 1'b0, 1'b0, 16'h0040, '0, 3, {16{8'hA5}});
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
      checkIdle("t1 after");
      checkOutput("t1 i_rdata hold", bus.i_rdata, {16{8'hA5}});
      checkOutput("t1 d_rdata untouched", bus.d_rdata, '0);

      $display("[TB] simultaneous requests");
      nextCycle();
      applyStimulus(1'b1, 16'h0200, 1'b0, 1'b1, 16'h1230, 128'h1);
      nextCycle();
      serveMem("t2 dwrite", 1'b1, 1'b1, 16'h1230, 128'h1, 2, 128'h0);
      // dcache re-requests alongside the still-pending icache read.
      lineA = {4{32'hCAFE_0001}};
      lineB = {4{32'hBEEF_0002}};
      applyStimulus(1'b1, 16'h0200, 1'b1, 1'b0, 16'h3000, '0);
      checkIdle("t2 turnaround");
      nextCycle();
`ifdef CACHE_ARB_RR_EN
      serveMem("t2 rr icache", 1'b0, 1'b0, 16'h0200, '0, 1, lineA);
      applyStimulus(1'b0, '0, 1'b1, 1'b0, 16'h3000, '0);
      checkIdle("t2 turnaround 2");
      nextCycle();
      serveMem("t2 rr dcache", 1'b1, 1'b0, 16'h3000, '0, 1, lineB);
`else
      serveMem("t2 fixed dcache", 1'b1, 1'b0, 16'h3000, '0, 1, lineB);
      applyStimulus(1'b1, 16'h0200, 1'b0, 1'b0, '0, '0);
      checkIdle("t2 turnaround 2");
      nextCycle();
      serveMem("t2 fixed icache", 1'b0, 1'b0, 16'h0200, '0, 1, lineA);
`endif
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
      checkIdle("t2 after");

      $display("[TB] request drop mid-serve");
      nextCycle();
      applyStimulus(1'b0, '0, 1'b1, 1'b0, 16'h0080, '0);
      nextCycle();
      @(negedge clk);
      checkOutput("t3 granted read", bus.pmem_read, 1'b1);
      nextCycle();
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 16'hFFFF, '0);
      serveMem("t3 dropped", 1'b1, 1'b0, 16'h0080, '0, 2, {4{32'h1357_9BDF}});
      checkIdle("t3 after");

      $display("[TB] async reset mid-transaction");
      nextCycle();
      applyStimulus(1'b1, 16'h0100, 1'b0, 1'b0, '0, '0);
      nextCycle();
      @(negedge clk);
      checkOutput("t4 serving", bus.pmem_read, 1'b1);
      #1;
      rst_n = 1'b0;
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
      #1;
      checkOutput("t4 async pmem_read", bus.pmem_read, 1'b0);
      checkOutput("t4 async busy", bus.busy, 1'b0);
      checkOutput("t4 i_rdata cleared", bus.i_rdata, '0);
      checkOutput("t4 d_rdata cleared", bus.d_rdata, '0);
      nextCycle();
      rst_n = 1'b1;
      nextCycle();
      nextCycle();
      bus.pmem_rdata = {4{32'hDEAD_BEEF}};
      bus.pmem_resp  = 1'b1;
      @(negedge clk);
      checkOutput("t4 late i_resp", bus.i_resp, 1'b0);
      checkOutput("t4 late d_resp", bus.d_resp, 1'b0);
      nextCycle();
      bus.pmem_resp = 1'b0;
      checkIdle("t4 after");

      $display("[TB] stray response");
      nextCycle();
      bus.pmem_rdata = {4{32'h0BAD_F00D}};
      bus.pmem_resp  = 1'b1;
      @(negedge clk);
      checkOutput("t5 i_resp", bus.i_resp, 1'b0);
      checkOutput("t5 d_resp", bus.d_resp, 1'b0);
      checkOutput("t5 busy", bus.busy, 1'b0);
      nextCycle();
      bus.pmem_resp = 1'b0;
      checkIdle("t5 after");

      $display("[TB] back-to-back dcache");
      nextCycle();
      applyStimulus(1'b0, '0, 1'b1, 1'b0, 16'h0000, '0);
      nextCycle();
      serveMem("t6 first", 1'b1, 1'b0, 16'h0000, '0, 1, {4{32'h1111_2222}});
      applyStimulus(1'b0, '0, 1'b1, 1'b0, 16'h0010, '0);
      checkIdle("t6 gap");
      nextCycle();
      serveMem("t6 second", 1'b1, 1'b0, 16'h0010, '0, 1, {4{32'h3333_4444}});
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
      checkIdle("t6 after");
      checkOutput("t6 d_rdata hold", bus.d_rdata, {4{32'h3333_4444}});

      nextCycle();
      checkOutput("scoreboard drained", expQ.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
